// File: rtl/imm_ext_arbiter.sv
// Two-requester round-robin arbiter feeding one shared immediate-extension unit
// and a single-entry result register with full back-to-back throughput.
module imm_ext_arbiter #(
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [15:0]     req0_imm,
  input  logic [1:0]      req0_mode,
  input  logic [TAGW-1:0] req0_tag,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [15:0]     req1_imm,
  input  logic [1:0]      req1_mode,
  input  logic [TAGW-1:0] req1_tag,
  output logic            req1_ready,
  output logic            out_valid,
  output logic [31:0]     out_data,
  output logic            out_src,
  output logic [TAGW-1:0] out_tag,
  input  logic            out_ready
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // reqN_ready depends only on the valids, prio, out_valid, out_ready and reset, so
  // it never loops back through the imm/mode/tag payload.
  typedef enum logic [1:0] {
    MODE_SEXT   = 2'b00,
    MODE_ZEXT   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  logic            prio;
  logic            space;
  logic            grant0;
  logic            grant1;
  logic            grant;
  logic [15:0]     sel_imm;
  logic [1:0]      sel_mode;
  logic [TAGW-1:0] sel_tag;
  logic [31:0]     ext_data;

  assign space  = !out_valid || out_ready;
  assign grant0 = !reset && space && req0_valid && (!req1_valid || (prio == 1'b0));
  assign grant1 = !reset && space && req1_valid && (!req0_valid || (prio == 1'b1));
  assign grant  = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    sel_imm  = req0_imm;
    sel_mode = req0_mode;
    sel_tag  = req0_tag;
    if (grant1) begin
      sel_imm  = req1_imm;
      sel_mode = req1_mode;
      sel_tag  = req1_tag;
    end
  end

  always_comb begin
    ext_data = 32'h0;
    case (mode_e'(sel_mode))
      MODE_SEXT:   ext_data = {{16{sel_imm[15]}}, sel_imm};
      MODE_ZEXT:   ext_data = {16'h0, sel_imm};
      MODE_UPPER:  ext_data = {sel_imm, 16'h0};
      MODE_BRANCH: ext_data = {{14{sel_imm[15]}}, sel_imm, 2'b00};
      default:     ext_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_src   <= 1'b0;
      out_tag   <= '0;
      prio      <= 1'b0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= ext_data;
      out_src   <= grant1;
      out_tag   <= sel_tag;
      // Priority moves to whichever requester lost (or was idle) this cycle.
      prio      <= grant0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter: reset, extension modes, round-robin order,
// back-pressure and reset with a pending result.
module tb_imm_ext_arbiter;
  localparam int TAGW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req0_valid, req1_valid;
  logic [15:0]     req0_imm, req1_imm;
  logic [1:0]      req0_mode, req1_mode;
  logic [TAGW-1:0] req0_tag, req1_tag;
  logic            req0_ready, req1_ready;
  logic            out_valid;
  logic [31:0]     out_data;
  logic            out_src;
  logic [TAGW-1:0] out_tag;
  logic            out_ready;

  int n_checks = 0;
  int n_fail = 0;

  imm_ext_arbiter #(.TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_imm(req0_imm), .req0_mode(req0_mode),
    .req0_tag(req0_tag), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_imm(req1_imm), .req1_mode(req1_mode),
    .req1_tag(req1_tag), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_tag(out_tag), .out_ready(out_ready)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_imm = 16'h0; req0_mode = 2'b00; req0_tag = '0;
    req1_valid = 1'b0; req1_imm = 16'h0; req1_mode = 2'b00; req1_tag = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b1;
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      $display("FAIL reset_ready_hold: got %b expected 00", {req0_ready, req1_ready}); n_fail++;
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid: got %b expected 0", out_valid); n_fail++;
    end
    n_checks++;
    if (out_data !== 32'h0) begin
      $display("FAIL reset_out_data: got %h expected 00000000", out_data); n_fail++;
    end
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      $display("FAIL reset_ready_idle: got %b expected 00", {req0_ready, req1_ready}); n_fail++;
    end
  endtask

  task automatic test_sign_ext();
    req0_valid = 1'b1; req0_imm = 16'hFFFE; req0_mode = 2'b00; req0_tag = 4'd3;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL sext_ready: got %b expected 10", {req0_ready, req1_ready}); n_fail++;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL sext_valid: got %b expected 1", out_valid); n_fail++;
    end
    n_checks++;
    if (out_data !== 32'hFFFFFFFE) begin
      $display("FAIL sext_data: got %h expected fffffffe", out_data); n_fail++;
    end
    n_checks++;
    if (out_src !== 1'b0 || out_tag !== 4'd3) begin
      $display("FAIL sext_src_tag: got %b/%0d expected 0/3", out_src, out_tag); n_fail++;
    end
  endtask

  task automatic test_modes();
    logic [15:0] imms[4]  = '{16'h8000, 16'h1234, 16'h8000, 16'h0005};
    logic [1:0]  modes[4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    logic [31:0] exp_d[4] = '{32'h00008000, 32'h12340000, 32'hFFFE0000, 32'h00000014};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req1_valid = 1'b1; req1_imm = imms[i]; req1_mode = modes[i]; req1_tag = 4'(i + 8);
      #1;
      n_checks++;
      if (req1_ready !== 1'b1) begin
        $display("FAIL mode%0d_ready: got %b expected 1", i, req1_ready); n_fail++;
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_src !== 1'b1 || out_tag !== 4'(i + 8)) begin
        $display("FAIL mode%0d_result: got v=%b d=%h s=%b t=%0d expected v=1 d=%h s=1 t=%0d",
                 i, out_valid, out_data, out_src, out_tag, exp_d[i], i + 8);
        n_fail++;
      end
    end
    req1_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL drain_valid: got %b expected 0", out_valid); n_fail++;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_imm = 16'h0001; req0_mode = 2'b01; req0_tag = 4'd1;
    req1_valid = 1'b1; req1_imm = 16'h0002; req1_mode = 2'b01; req1_tag = 4'd2;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== 1'((i - 1) % 2) || out_tag !== 4'(((i - 1) % 2) + 1)) begin
          $display("FAIL rr_out%0d: got v=%b s=%b t=%0d expected v=1 s=%0d t=%0d",
                   i - 1, out_valid, out_src, out_tag, (i - 1) % 2, ((i - 1) % 2) + 1);
          n_fail++;
        end
      end
      if (i == 4) break;
      #1;
      exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
      n_checks++;
      if ({req0_ready, req1_ready} !== exp_rdy) begin
        $display("FAIL rr_grant%0d: got %b expected %b", i, {req0_ready, req1_ready}, exp_rdy); n_fail++;
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_imm = 16'h0011; req0_mode = 2'b01; req0_tag = 4'd5;
    @(negedge clk);
    out_ready = 1'b0;
    req0_imm = 16'h0022; req0_tag = 4'd6;
    req1_valid = 1'b1; req1_imm = 16'h0033; req1_mode = 2'b01; req1_tag = 4'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        $display("FAIL bp_ready%0d: got %b expected 00", i, {req0_ready, req1_ready}); n_fail++;
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h00000011 || out_tag !== 4'd5) begin
        $display("FAIL bp_hold%0d: got v=%b d=%h t=%0d expected v=1 d=00000011 t=5",
                 i, out_valid, out_data, out_tag);
        n_fail++;
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      $display("FAIL bp_release_grant: got %b expected 01", {req0_ready, req1_ready}); n_fail++;
    end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00000033 || out_src !== 1'b1 || out_tag !== 4'd7) begin
      $display("FAIL bp_new_result: got v=%b d=%h s=%b t=%0d expected v=1 d=00000033 s=1 t=7",
               out_valid, out_data, out_src, out_tag);
      n_fail++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_pending();
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_imm = 16'h0044; req0_mode = 2'b01; req0_tag = 4'd9;
    @(negedge clk);
    // prio now points at requester 1; reset must bring it back to 0
    out_ready = 1'b0;
    req1_valid = 1'b1; req1_imm = 16'h0055; req1_mode = 2'b01; req1_tag = 4'd10;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      $display("FAIL rstp_ready: got %b expected 00", {req0_ready, req1_ready}); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      $display("FAIL rstp_discard: got v=%b d=%h expected v=0 d=00000000", out_valid, out_data); n_fail++;
    end
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL rstp_first_grant: got %b expected 10", {req0_ready, req1_ready}); n_fail++;
    end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b0 || out_tag !== 4'd9) begin
      $display("FAIL rstp_result: got v=%b s=%b t=%0d expected v=1 s=0 t=9", out_valid, out_src, out_tag); n_fail++;
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_sign_ext();
    test_modes();
    test_round_robin();
    test_backpressure();
    test_reset_pending();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
